// File: rtl/prbs_checker_if.sv
// Bus between a PRBS checker and its stimulus/observer.
// The slave modport is the checker side; master is the driving side.
interface prbs_checker_if #(
  parameter int CNT_W = 32
);
  logic             control;
  logic             rx_valid;
  logic             rx_bit;
  logic             clear_counts;
  logic             locked;
  logic [CNT_W-1:0] bit_count;
  logic [CNT_W-1:0] err_count;
  logic             err_pulse;

  modport master (
    output control, rx_valid, rx_bit, clear_counts,
    input  locked, bit_count, err_count, err_pulse
  );

  modport slave (
    input  control, rx_valid, rx_bit, clear_counts,
    output locked, bit_count, err_count, err_pulse
  );
endinterface

// File: rtl/prbs_checker.sv
// PRBS-7 / PRBS-13 serial pattern checker with lock FSM and saturating
// bit/error statistics.
// Optional feature: define PRBS_CHK_AUTO_RELOCK_EN to drop lock when too many
// errors land in one window of LOSS_WINDOW valid beats.
module prbs_checker #(
  parameter int LOCK_COUNT  = 16,
  parameter int LOSS_ERRS   = 8,
  parameter int LOSS_WINDOW = 64,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  prbs_checker_if.slave   bus
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam int MW = $clog2(LOCK_COUNT + 1);
  typedef logic [MW-1:0] match_t;
  // Compare that still matches at this count is the one that reaches LOCK_COUNT.
  localparam match_t LOCK_LAST = match_t'(LOCK_COUNT - 1);

  state_t           state, state_nxt;
  logic             ctrl_q;       // pattern select the shift register is running
  logic [12:0]      s;            // PRBS-7 uses s[6:0] only
  logic [3:0]       fill_cnt;
  match_t           match_cnt;
  logic [CNT_W-1:0] bit_cnt, err_cnt;
  logic             err_pulse_q;

  logic ctrl_change, beat, predicted, fill_done, mismatch;
  logic lock_hit, locked_beat, loss_hit;

`ifdef PRBS_CHK_AUTO_RELOCK_EN
  localparam int WBW = $clog2(LOSS_WINDOW + 1);
  localparam int WEW = $clog2(LOSS_ERRS + 1);
  localparam logic [WBW-1:0] WIN_LAST  = WBW'(LOSS_WINDOW - 1);
  localparam logic [WEW-1:0] LOSS_LAST = WEW'(LOSS_ERRS - 1);
  logic [WBW-1:0] win_beats;
  logic [WEW-1:0] win_errs;
`endif

  // Beat qualification, pattern prediction and FSM event decode.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ctrl_change = (bus.control != ctrl_q);
    beat        = bus.rx_valid && !ctrl_change;
    predicted   = ctrl_q ? (s[12] ^ s[11] ^ s[10] ^ s[7]) : (s[6] ^ s[5]);
    fill_done   = (fill_cnt == (ctrl_q ? 4'd13 : 4'd7));
    mismatch    = bus.rx_bit ^ predicted;
    lock_hit    = (state == SEARCH) && beat && fill_done && !mismatch &&
                  (match_cnt == LOCK_LAST);
    locked_beat = (state == LOCKED) && beat;
    loss_hit    = 1'b0;
`ifdef PRBS_CHK_AUTO_RELOCK_EN
    loss_hit    = locked_beat && mismatch && (win_errs == LOSS_LAST);
`endif
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEARCH;
    else        state <= state_nxt;
  end

  // FSM next-state: control change always restarts the search.
  always_comb begin
    state_nxt = state;
    if (ctrl_change) begin
      state_nxt = SEARCH;
    end else begin
      case (state)
        SEARCH:  if (lock_hit) state_nxt = LOCKED;
        LOCKED:  if (loss_hit) state_nxt = SEARCH;
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // FSM outputs and counter exposure.
  always_comb begin
    bus.locked    = (state == LOCKED);
    bus.bit_count = bit_cnt;
    bus.err_count = err_cnt;
    bus.err_pulse = err_pulse_q;
  end

  // Shift register, fill counter and match counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= 1'b0;
      s         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
    end else if (ctrl_change) begin
      ctrl_q    <= bus.control;
      fill_cnt  <= '0;
      match_cnt <= '0;
    end else if (beat) begin
      if (state == SEARCH) begin
        s <= {s[11:0], bus.rx_bit};
        if (!fill_done)                fill_cnt  <= fill_cnt + 4'd1;
        else if (mismatch || lock_hit) match_cnt <= '0;
        else                           match_cnt <= match_cnt + 1'b1;
      end else begin
        // Self-running once locked: a corrupted rx_bit never enters s.
        s <= {s[11:0], predicted};
        if (loss_hit) begin
          fill_cnt  <= '0;
          match_cnt <= '0;
        end
      end
    end
  end

  // Saturating statistics; clear and control change win over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      err_cnt <= '0;
    end else if (bus.clear_counts || ctrl_change) begin
      bit_cnt <= '0;
      err_cnt <= '0;
    end else if (locked_beat) begin
      if (bit_cnt != '1)             bit_cnt <= bit_cnt + 1'b1;
      if (mismatch && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

  // Error strobe, one cycle after each counted mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_pulse_q <= 1'b0;
    else        err_pulse_q <= locked_beat && mismatch && !bus.clear_counts;
  end

`ifdef PRBS_CHK_AUTO_RELOCK_EN
  // Sync-loss window: beats and errors, zeroed at each window end or exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_beats <= '0;
      win_errs  <= '0;
    end else if (ctrl_change || loss_hit) begin
      win_beats <= '0;
      win_errs  <= '0;
    end else if (locked_beat) begin
      if (win_beats == WIN_LAST) begin
        win_beats <= '0;
        win_errs  <= '0;
      end else begin
        win_beats <= win_beats + 1'b1;
        if (mismatch) win_errs <= win_errs + 1'b1;
      end
    end
  end
`endif

endmodule
